seq_mul_acc: RTL and testbench

- Parametrised multi-cycle shift-add multiplier / multiply-accumulator for the mini processor datapath on the BUS.
- Replaces fixed-width combinational multiply built from cla32 stages with a sequential radix-2 engine.
- Adds generic WIDTH, signed/unsigned mode, MAC mode, and a start/busy/done handshake.
- Uses one WIDTH+1-bit adder per cycle.

---
 rtl/seq_mul_acc_if.sv | 29 ++
 rtl/seq_mul_acc.sv | 118 +++++++++++
 tb/tb_seq_mul_acc.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mul_acc_if.sv
// Operation request / result bus of the sequential multiply-accumulate unit.
// The master issues operations; the slave (seq_mul_acc) returns busy/done/result.
interface seq_mul_acc_if #(
   parameter int WIDTH = 32
);
   // Handshake: op_start is accepted on a rising edge only while busy=0; operands
   // and modes are latched with it. busy stays high for the whole RUN phase and
   // done pulses for exactly one cycle in which result carries the new value.
   logic                   op_start;
   logic                   op_signed;
   logic                   op_acc;
   logic                   op_clear;
   logic [WIDTH-1:0]       op_a;
   logic [WIDTH-1:0]       op_b;
   logic                   busy;
   logic                   done;
   logic [2*WIDTH-1:0]     result;
   logic [1:0]             state;

   modport master (
      output op_start, op_signed, op_acc, op_clear, op_a, op_b,
      input  busy, done, result, state
   );

   modport slave (
      input  op_start, op_signed, op_acc, op_clear, op_a, op_b,
      output busy, done, result, state
   );
endinterface

// File: rtl/seq_mul_acc.sv
// Radix-2 shift-add multiplier / multiply-accumulator with a start/busy/done handshake.
// Optional macro MUL_EARLY_TERM_EN ends RUN once the remaining multiplier bits are zero.
module seq_mul_acc #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   seq_mul_acc_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;
   logic [2*WIDTH-1:0]   partial;
   logic [CW-1:0]        cnt;
   logic                 neg;
   logic                 acc_mode;
   logic                 acc_zero;
   logic                 busy_r;
   logic                 done_r;
   logic [2*WIDTH-1:0]   result_r;

   logic [WIDTH:0]       add_sum;
   logic [2*WIDTH-1:0]   partial_step;
   logic [2*WIDTH-1:0]   partial_final;
   logic [2*WIDTH-1:0]   prod;
   logic [2*WIDTH-1:0]   acc_base;
   logic [2*WIDTH-1:0]   result_next;
   logic [WIDTH-1:0]     mplier_step;
   logic [WIDTH-1:0]     abs_a;
   logic [WIDTH-1:0]     abs_b;
   logic                 last_step;

   always_comb begin
      add_sum      = {1'b0, partial[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
      partial_step = (2*WIDTH)'({add_sum, partial[WIDTH-1:0]} >> 1);
      mplier_step  = mplier >> 1;
`ifdef MUL_EARLY_TERM_EN
      // Remaining shifts are applied in one go so the product lands where the
      // fixed-latency engine would have put it.
      last_step     = (cnt == CW'(1)) || (mplier_step == '0);
      partial_final = partial_step >> (cnt - CW'(1));
`else
      last_step     = (cnt == CW'(1));
      partial_final = partial_step;
`endif
      prod        = neg ? -partial_final : partial_final;
      acc_base    = acc_zero ? '0 : result_r;
      result_next = acc_mode ? acc_base + prod : prod;
      // Magnitudes are WIDTH-bit unsigned, so |-2^(WIDTH-1)| is representable.
      abs_a = (bus.op_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
      abs_b = (bus.op_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         mcand    <= '0;
         mplier   <= '0;
         partial  <= '0;
         cnt      <= '0;
         neg      <= 1'b0;
         acc_mode <= 1'b0;
         acc_zero <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_r <= 1'b0;
               if (bus.op_start) begin
                  mcand    <= abs_a;
                  mplier   <= abs_b;
                  neg      <= bus.op_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                  acc_mode <= bus.op_acc;
                  acc_zero <= bus.op_clear;
                  partial  <= '0;
                  cnt      <= CW'(WIDTH);
                  busy_r   <= 1'b1;
                  state    <= RUN;
               end else begin
                  if (bus.op_clear) result_r <= '0;
                  state <= IDLE;
               end
            end
            RUN: begin
               partial <= partial_step;
               mplier  <= mplier_step;
               cnt     <= cnt - CW'(1);
               if (last_step) begin
                  result_r <= result_next;
                  busy_r   <= 1'b0;
                  done_r   <= 1'b1;
                  state    <= DONE;
               end
            end
            default: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.result = result_r;
   assign bus.state  = state;
endmodule

// File: tb/tb_seq_mul_acc.sv
// Directed bench for seq_mul_acc (WIDTH=32): vector table plus hand-written
// sequences for back-to-back starts, ignored starts while busy and reset mid-run.
module tb_seq_mul_acc;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   seq_mul_acc_if #(.WIDTH(W)) bus ();
   seq_mul_acc #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      bit          pre_clear;
      bit          sgn;
      bit          acc;
      bit          clr;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t        vecs[14];
   logic [63:0] exp_q[$];
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected RUN length: bit-length of |b| (min 1) with early termination, else W.
   function automatic int run_cycles(input bit sgn, input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
      logic [31:0] m;
      int n;
      m = (sgn && b[31]) ? -b : b;
      n = 0;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      return (n < 1) ? 1 : n;
`else
      return W;
`endif
   endfunction

   task automatic wait_done(output int cyc, output int bcnt, output bit seen);
      cyc = 0;
      bcnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         cyc++;
         if (bus.busy) bcnt++;
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic start_op(input bit sgn, input bit acc, input bit clr,
                           input logic [31:0] a, input logic [31:0] b);
      bus.op_start  = 1'b1;
      bus.op_signed = sgn;
      bus.op_acc    = acc;
      bus.op_clear  = clr;
      bus.op_a      = a;
      bus.op_b      = b;
      @(posedge clk);
      #1;
      bus.op_start  = 1'b0;
      bus.op_clear  = 1'b0;
      bus.op_a      = $urandom;
      bus.op_b      = $urandom;
      bus.op_signed = 1'($urandom_range(0, 1));
      bus.op_acc    = 1'($urandom_range(0, 1));
   endtask

   task automatic finish_op(input string name, input int runs);
      int cyc, bcnt;
      bit seen;
      logic [63:0] e;
      wait_done(cyc, bcnt, seen);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      check({name, "_done_seen"}, 64'(seen), 64'd1);
      check({name, "_latency"}, 64'(cyc), 64'(runs + 1));
      check({name, "_busy_cycles"}, 64'(bcnt), 64'(runs));
      check({name, "_result"}, bus.result, e);
      check({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
   endtask

   task automatic run_op(input string name, input bit sgn, input bit acc, input bit clr,
                         input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
      @(negedge clk);
      exp_q.push_back(exp);
      start_op(sgn, acc, clr, a, b);
      finish_op(name, run_cycles(sgn, b));
      @(negedge clk);
      check({name, "_done_one_cycle"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, bcnt, pulses, first_done;
      bit seen;
      logic [63:0] res_at_done;

      vecs[0]  = '{0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
      vecs[1]  = '{0, 1, 0, 0, 32'hFFFFFFF9, 32'h00000006, 64'hFFFFFFFFFFFFFFD6};
      vecs[2]  = '{0, 1, 0, 0, 32'h80000000, 32'h80000000, 64'h4000000000000000};
      vecs[3]  = '{0, 0, 0, 0, 32'h00000000, 32'h12345678, 64'h0000000000000000};
      vecs[4]  = '{0, 0, 0, 0, 32'h80000000, 32'h00000003, 64'h0000000180000000};
      vecs[5]  = '{0, 1, 0, 0, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000};
      vecs[6]  = '{1, 0, 1, 0, 32'h00000003, 32'h00000004, 64'd12};
      vecs[7]  = '{0, 0, 1, 0, 32'h00000005, 32'h00000006, 64'd42};
      vecs[8]  = '{0, 1, 1, 0, 32'hFFFFFFFE, 32'h0000000A, 64'd22};
      vecs[9]  = '{0, 0, 1, 1, 32'h00000002, 32'h00000002, 64'd4};
      vecs[10] = '{0, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000005};
      vecs[11] = '{0, 1, 1, 0, 32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFE00000004};
      vecs[12] = '{0, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1};
      vecs[13] = '{0, 1, 1, 0, 32'hFFFFFFFF, 32'h00000001, 64'd0};

      // Clock / reset
      reset = 1'b1;
      bus.op_start = 1'b0;
      bus.op_signed = 1'b0;
      bus.op_acc = 1'b0;
      bus.op_clear = 1'b0;
      bus.op_a = '0;
      bus.op_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_result", bus.result, 64'd0);
      check("reset_state", 64'(bus.state), 64'd0);
      reset = 1'b0;

      // Vector table
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].pre_clear) begin
            @(negedge clk);
            bus.op_clear = 1'b1;
            @(posedge clk);
            #1;
            bus.op_clear = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_clear_result", i), bus.result, 64'd0);
            check($sformatf("vec%0d_clear_no_done", i), 64'(bus.done), 64'd0);
         end
         run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].acc, vecs[i].clr,
                vecs[i].a, vecs[i].b, vecs[i].exp);
      end

      // Back-to-back: new start accepted in the done cycle
      @(negedge clk);
      exp_q.push_back(64'd6);
      start_op(0, 0, 0, 32'd2, 32'd3);
      finish_op("b2b_first", run_cycles(0, 32'd3));
      check("b2b_first_state_done", 64'(bus.state), 64'd2);
      exp_q.push_back(64'd20);
      start_op(0, 0, 0, 32'd4, 32'd5);
      finish_op("b2b_second", run_cycles(0, 32'd5));

      // Start and clear while busy are ignored
      @(negedge clk);
      start_op(0, 1, 0, 32'd3, 32'h000000F5);
      pulses = 0;
      first_done = 0;
      res_at_done = '0;
      for (int c = 1; c <= 2 * W + 10; c++) begin
         @(negedge clk);
         if (c == 2) begin
            bus.op_start = 1'b1;
            bus.op_clear = 1'b1;
            bus.op_a = 32'd100;
            bus.op_b = 32'd100;
         end else begin
            bus.op_start = 1'b0;
            bus.op_clear = 1'b0;
         end
         if (bus.done) begin
            pulses++;
            if (first_done == 0) begin
               first_done = c;
               res_at_done = bus.result;
            end
         end
      end
      check("busy_ignore_pulses", 64'(pulses), 64'd1);
      check("busy_ignore_latency", 64'(first_done), 64'(run_cycles(0, 32'h000000F5) + 1));
      check("busy_ignore_result", res_at_done, 64'h00000000000002F3);

      // Reset in the middle of RUN
      @(negedge clk);
      start_op(0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (10) @(negedge clk);
      check("midrun_busy_before_reset", 64'(bus.busy), 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrun_reset_busy", 64'(bus.busy), 64'd0);
      check("midrun_reset_result", bus.result, 64'd0);
      check("midrun_reset_state", 64'(bus.state), 64'd0);
      pulses = 0;
      for (int c = 0; c < W + 5; c++) begin
         @(negedge clk);
         if (bus.done) pulses++;
      end
      check("midrun_no_done", 64'(pulses), 64'd0);
      run_op("after_reset", 0, 0, 0, 32'd6, 32'd7, 64'd42);

      wait_done(cyc, bcnt, seen);
      check("idle_no_spurious_done", 64'(seen), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
